// File: rtl/step_motor_pkg.sv
// rtl/step_motor_pkg.sv - shared FSM states and coil phase table for the stepper sequencer
// Purpose: state encoding and the 8-entry half-step phase table.
// Each table entry packs {AX,AY,AE,BX,BY,BE}; a coil triple is {X,Y,E}.
package step_motor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [2:0] COIL_POS = 3'b101;
    localparam logic [2:0] COIL_NEG = 3'b011;
    localparam logic [2:0] COIL_OFF = 3'b000;

    // Odd entries energise both coils, so full-step (two-phase-on) moves live on odd indices.
    localparam logic [5:0] PHASE_TABLE [8] = '{
        {COIL_POS, COIL_OFF},
        {COIL_POS, COIL_POS},
        {COIL_OFF, COIL_POS},
        {COIL_NEG, COIL_POS},
        {COIL_NEG, COIL_OFF},
        {COIL_NEG, COIL_NEG},
        {COIL_OFF, COIL_NEG},
        {COIL_POS, COIL_NEG}
    };

endpackage

// File: rtl/step_phase_table.sv
// rtl/step_phase_table.sv - combinational phase index to coil drive lookup
// Purpose: map phase index to coil drive bits.
// Ports: idx (phase index 0..7) in; coils {AX,AY,AE,BX,BY,BE} out.
module step_phase_table
    import step_motor_pkg::*;
(
    input  logic [2:0] idx,
    output logic [5:0] coils
);

    assign coils = PHASE_TABLE[idx];

endmodule

// File: rtl/step_motor_sequencer.sv
// rtl/step_motor_sequencer.sv - single-axis bipolar stepper move sequencer
// Purpose: runs moves of N full or half steps at a fixed period, tracks signed position.
// Ports: clock, reset (sync active-high); start/stop move control; dir, half_step,
//        period, steps move setup; hold_en idle hold; AX/AY/AE, BX/BY/BE coil drive;
//        busy, done, aborted status; position signed half-step count.
module step_motor_sequencer
    import step_motor_pkg::*;
#(
    parameter int PERIOD_W = 32,
    parameter int STEPS_W  = 32,
    parameter int POS_W    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                dir,
    input  logic                half_step,
    input  logic [PERIOD_W-1:0] period,
    input  logic [STEPS_W-1:0]  steps,
    input  logic                hold_en,
    output logic                AX,
    output logic                AY,
    output logic                AE,
    output logic                BX,
    output logic                BY,
    output logic                BE,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [POS_W-1:0]    position
);

    state_t              state_q,     state_d;
    logic [PERIOD_W-1:0] cnt_q,       cnt_d;
    logic [PERIOD_W-1:0] period_q,    period_d;
    logic [STEPS_W-1:0]  remaining_q, remaining_d;
    logic                dir_q,       dir_d;
    logic                half_q,      half_d;
    logic [2:0]          idx_q,       idx_d;
    logic [POS_W-1:0]    pos_q,       pos_d;
    logic                aborted_q,   aborted_d;
    logic [5:0]          coils_q,     coils_d;

    logic [5:0]          table_coils;
    logic [2:0]          idx_delta;
    logic [POS_W-1:0]    pos_delta;

    step_phase_table u_phase_table (
        .idx   (idx_q),
        .coils (table_coils)
    );

    // Full-step from an even index moves one slot to reach the two-phase-on (odd) entries,
    // afterwards it moves two slots to stay on them.
    always_comb begin
        idx_delta = (half_q || !idx_q[0]) ? 3'd1 : 3'd2;
        pos_delta = half_q ? POS_W'(1) : POS_W'(2);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        half_d      = half_q;
        idx_d       = idx_q;
        pos_d       = pos_q;
        aborted_d   = aborted_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    dir_d       = dir;
                    half_d      = half_step;
                    period_d    = (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
                    remaining_d = steps;
                    cnt_d       = '0;
                    aborted_d   = 1'b0;
                    state_d     = (steps == '0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                // Stop takes priority over a step due on the same cycle.
                if (stop) begin
                    aborted_d = 1'b1;
                    state_d   = ST_FINISH;
                end else if (cnt_q == period_q - PERIOD_W'(1)) begin
                    cnt_d       = '0;
                    remaining_d = remaining_q - STEPS_W'(1);
                    idx_d       = dir_q ? idx_q + idx_delta : idx_q - idx_delta;
                    pos_d       = dir_q ? pos_q + pos_delta : pos_q - pos_delta;
                    if (remaining_q == STEPS_W'(1)) begin
                        state_d = ST_FINISH;
                    end
                end else begin
                    cnt_d = cnt_q + PERIOD_W'(1);
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        coils_d = ((state_q != ST_IDLE) || hold_en) ? table_coils : 6'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            period_q    <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            half_q      <= 1'b0;
            idx_q       <= 3'd0;
            pos_q       <= '0;
            aborted_q   <= 1'b0;
            coils_q     <= 6'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            half_q      <= half_d;
            idx_q       <= idx_d;
            pos_q       <= pos_d;
            aborted_q   <= aborted_d;
            coils_q     <= coils_d;
        end
    end

    assign {AX, AY, AE, BX, BY, BE} = coils_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FINISH);
    assign aborted  = aborted_q;
    assign position = pos_q;

endmodule

// File: tb/tb_step_motor_sequencer.sv
// tb/tb_step_motor_sequencer.sv - self-checking bench for step_motor_sequencer
module tb_step_motor_sequencer;

    localparam int POS_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic             dir;
    logic             half_step;
    logic [31:0]      period;
    logic [31:0]      steps;
    logic             hold_en;
    logic             AX, AY, AE, BX, BY, BE;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [POS_W-1:0] position;

    int n_checks = 0;
    int n_errors = 0;
    int m_idx    = 0;
    int m_pos    = 0;

    step_motor_sequencer #(
        .PERIOD_W (32),
        .STEPS_W  (32),
        .POS_W    (POS_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .dir       (dir),
        .half_step (half_step),
        .period    (period),
        .steps     (steps),
        .hold_en   (hold_en),
        .AX        (AX),
        .AY        (AY),
        .AE        (AE),
        .BX        (BX),
        .BY        (BY),
        .BE        (BE),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .position  (position)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Coil triple {X,Y,E} for polarity +1 / -1 / 0.
    function automatic logic [2:0] coil_of(input int s);
        if (s > 0)      return 3'b101;
        else if (s < 0) return 3'b011;
        else            return 3'b000;
    endfunction

    function automatic logic [5:0] phase(input int i);
        int a [8] = '{1, 1, 0, -1, -1, -1, 0, 1};
        int b [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
        return {coil_of(a[i]), coil_of(b[i])};
    endfunction

    function automatic int idx_after(input int i0, input int k, input bit d, input bit h);
        int i = i0;
        int s = d ? 1 : -1;
        for (int j = 0; j < k; j++) begin
            if (h || (i % 2 == 0)) i = i + s;
            else                   i = i + 2 * s;
            i = ((i % 8) + 8) % 8;
        end
        return i;
    endfunction

    function automatic logic [31:0] pos_bits(input int p);
        return 32'(p & ((1 << POS_W) - 1));
    endfunction

    function automatic logic [31:0] coils_now();
        return {26'd0, AX, AY, AE, BX, BY, BE};
    endfunction

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; stop = 1'b0; hold_en = 1'b0;
        @(posedge clock); #1;
        chk("rst_coils", coils_now(), 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_aborted", {31'd0, aborted}, 32'd0);
        chk("rst_position", {28'd0, position}, 32'd0);
        reset = 1'b0;
        m_idx = 0;
        m_pos = 0;
    endtask

    task automatic idle_step(input bit hold);
        start = 1'b0; stop = 1'($urandom_range(0, 1)); hold_en = hold;
        @(posedge clock); #1;
        chk("idle_coils", coils_now(), hold ? {26'd0, phase(m_idx)} : 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_position", {28'd0, position}, pos_bits(m_pos));
    endtask

    // One move from IDLE. ts>0 asserts stop before that edge (edge 0 samples start).
    task automatic run_move(input bit d, input bit h, input int p, input int n,
                            input int ts, input bit hold, input bit spam_start);
        int pe, tend, nend, k, kp, mult;
        bit ab, busy_prev;
        logic [5:0] exp_coils;
        pe   = (p < 2) ? 2 : p;
        mult = (d ? 1 : -1) * (h ? 1 : 2);
        if (n > 0 && ts >= 1 && ts <= n * pe) begin
            tend = ts; nend = (ts - 1) / pe; ab = 1'b1;
        end else begin
            tend = n * pe; nend = n; ab = 1'b0;
        end
        hold_en = hold;
        for (int t = 0; t <= tend + 2; t++) begin
            if (t == 0) begin
                start = 1'b1; stop = 1'b0; dir = d; half_step = h;
                period = 32'(p); steps = 32'(n);
            end else begin
                start = (t <= tend + 1) && (spam_start || ($urandom_range(0, 3) == 0));
                stop  = (t == ts);
                dir = 1'($urandom); half_step = 1'($urandom);
                period = $urandom; steps = $urandom;
            end
            @(posedge clock); #1;
            k = t / pe;
            if (k > nend) k = nend;
            if (t == 0) begin
                kp = 0; busy_prev = 1'b0;
            end else begin
                kp = (t - 1) / pe;
                if (kp > nend) kp = nend;
                busy_prev = (t - 1 <= tend);
            end
            exp_coils = (busy_prev || hold) ? phase(idx_after(m_idx, kp, d, h)) : 6'd0;
            chk("mv_coils", coils_now(), {26'd0, exp_coils});
            chk("mv_xy_excl", {31'd0, (AX & AY) | (BX & BY)}, 32'd0);
            chk("mv_busy", {31'd0, busy}, {31'd0, t <= tend});
            chk("mv_done", {31'd0, done}, {31'd0, t == tend});
            chk("mv_aborted", {31'd0, aborted}, {31'd0, ab && t >= tend});
            chk("mv_position", {28'd0, position}, pos_bits(m_pos + mult * k));
        end
        start = 1'b0; stop = 1'b0;
        m_idx = idx_after(m_idx, nend, d, h);
        m_pos = m_pos + mult * nend;
    endtask

    task automatic reset_mid_move();
        hold_en = 1'b0;
        start = 1'b1; stop = 1'b0; dir = 1'b1; half_step = 1'b1; period = 32'd3; steps = 32'd5;
        @(posedge clock);
        start = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("midrst_coils", coils_now(), 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_position", {28'd0, position}, 32'd0);
        reset = 1'b0;
        m_idx = 0;
        m_pos = 0;
        for (int i = 0; i < 3; i++) idle_step(1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; half_step = 1'b0;
        period = 32'd0; steps = 32'd0; hold_en = 1'b0;
        repeat (3) @(posedge clock);
        do_reset();

        // Half-step forward, period 4, three steps; ends at idx 3, position 3.
        run_move(1'b1, 1'b1, 4, 3, 0, 1'b0, 1'b0);
        // Hold in IDLE at idx 3, then release.
        idle_step(1'b1);
        idle_step(1'b0);

        // Full-step reverse from idx 0: 7,5,3,1 and position -8.
        do_reset();
        run_move(1'b0, 1'b0, 2, 4, 0, 1'b0, 1'b0);

        // Period clamp and zero-step move.
        run_move(1'b1, 1'b1, 0, 2, 0, 1'b0, 1'b0);
        run_move(1'b1, 1'b0, 1, 0, 0, 1'b1, 1'b0);

        // Stop coincident with the second step, then a move that clears aborted.
        run_move(1'b1, 1'b1, 3, 5, 6, 1'b0, 1'b0);
        run_move(1'b0, 1'b1, 2, 1, 0, 1'b0, 1'b0);

        // Starts hammered during RUN and FINISH.
        run_move(1'b1, 1'b0, 3, 3, 0, 1'b1, 1'b1);

        reset_mid_move();

        // Position wraps 7 -> -8 in a 4-bit counter.
        run_move(1'b1, 1'b1, 2, 8, 0, 1'b0, 1'b0);

        for (int r = 0; r < 40; r++) begin
            int p, n, ts, pe;
            p  = $urandom_range(0, 5);
            n  = $urandom_range(0, 6);
            pe = (p < 2) ? 2 : p;
            ts = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n * pe + 2) : 0;
            run_move(1'($urandom), 1'($urandom), p, n, ts, 1'($urandom), 1'b0);
            for (int i = 0; i < $urandom_range(0, 3); i++) idle_step(1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
